// File: rtl/alu_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer_pkg
// Description : Shared definitions for the ALU command sequencer: default
//               data widths, overflow counter width and FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_cmd_sequencer_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_OPC_W = 3;
  localparam int OVF_CNT_W = 8;

  localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Synchronous command FIFO, DEPTH x DATA_W, registered storage
//               with the head entry presented combinationally. Push is
//               ignored when full, pop is ignored when empty; a simultaneous
//               push and pop leaves the occupancy unchanged.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               push, push_data    - write request / data
//               full               - no free entry
//               pop                - remove head entry
//               head, empty        - head entry / no entry held
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
  parameter int DATA_W = 35,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty
);

  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset: contents are only observed through head when
  // count says the entry is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Initiator for a combinational 16-bit ALU. Commands are
//               queued in a FIFO, popped into registered operand outputs,
//               held for SETTLE cycles, then the ALU result is captured into
//               a response register with valid/ready back-pressure. Counts
//               overflowed results in a saturating counter.
// Ports       : clk, rst                      - clock, sync active-high reset
//               cmd_valid/ready, cmd_a/b/opc  - command input handshake
//               alu_inp1/inp2/opc             - registered operands to ALU
//               alu_out, alu_overflow         - ALU result inputs
//               rsp_valid/ready, rsp_out/
//               rsp_overflow/rsp_opc          - captured response handshake
//               ovf_clr, ovf_count            - overflow counter clear/value
//               busy                          - work pending or in flight
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int OPC_W  = DEF_OPC_W,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic [OPC_W-1:0]     cmd_opc,
  output logic [WIDTH-1:0]     alu_inp1,
  output logic [WIDTH-1:0]     alu_inp2,
  output logic [OPC_W-1:0]     alu_opc,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_out,
  output logic                 rsp_overflow,
  output logic [OPC_W-1:0]     rsp_opc,
  input  logic                 ovf_clr,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output logic                 busy
);

  localparam int ENTRY_W = 2 * WIDTH + OPC_W;
  localparam int CNT_W   = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  seq_state_t         state;
  seq_state_t         next_state;
  logic [CNT_W-1:0]   settle_cnt;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               load;
  logic               capture;
  logic               rsp_done;

  assign push_data = {cmd_a, cmd_b, cmd_opc};
  assign cmd_ready = !fifo_full;
  assign busy      = (state != S_IDLE) || !fifo_empty;

  alu_cmd_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // load always accompanies pop: the head entry goes straight into the
  // operand registers on the same edge it leaves the FIFO.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          load       = 1'b1;
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (settle_cnt == CNT_W'(1)) begin
          capture    = 1'b1;
          next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          if (!fifo_empty) begin
            pop        = 1'b1;
            load       = 1'b1;
            next_state = S_WAIT;
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Operand registers only change on a pop, so the ALU sees stable inputs
  // from one load to the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_inp1   <= '0;
      alu_inp2   <= '0;
      alu_opc    <= '0;
      settle_cnt <= '0;
    end else begin
      if (load) begin
        alu_inp1   <= head[ENTRY_W-1 -: WIDTH];
        alu_inp2   <= head[OPC_W +: WIDTH];
        alu_opc    <= head[OPC_W-1:0];
        settle_cnt <= CNT_W'(SETTLE);
      end else if (state == S_WAIT) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
    end
  end

  // A capture and a handshake never coincide: capture happens in WAIT, the
  // handshake only in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_out      <= '0;
      rsp_overflow <= 1'b0;
      rsp_opc      <= '0;
    end else begin
      if (capture) begin
        rsp_valid    <= 1'b1;
        rsp_out      <= alu_out;
        rsp_overflow <= alu_overflow;
        rsp_opc      <= alu_opc;
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end else if (capture && alu_overflow && (ovf_count != OVF_CNT_MAX)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Directed bench for alu_cmd_sequencer with a stub ALU and a
//               response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [2:0]  cmd_opc = '0;
  logic [15:0] alu_inp1;
  logic [15:0] alu_inp2;
  logic [2:0]  alu_opc;
  logic [15:0] alu_out;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_out;
  logic        rsp_overflow;
  logic [2:0]  rsp_opc;
  logic        ovf_clr = 1'b0;
  logic [7:0]  ovf_count;
  logic        busy;

  logic        toggle_en = 1'b0;
  logic [15:0] toggle_val = 16'h1111;
  logic        force_ovf = 1'b0;

  logic [19:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .WIDTH  (16),
    .OPC_W  (3),
    .DEPTH  (4),
    .SETTLE (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_opc      (cmd_opc),
    .alu_inp1     (alu_inp1),
    .alu_inp2     (alu_inp2),
    .alu_opc      (alu_opc),
    .alu_out      (alu_out),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_out      (rsp_out),
    .rsp_overflow (rsp_overflow),
    .rsp_opc      (rsp_opc),
    .ovf_clr      (ovf_clr),
    .ovf_count    (ovf_count),
    .busy         (busy)
  );

  function automatic logic [15:0] stub_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] opc);
    case (opc)
      3'b001:  return a + b;
      3'b010:  return a ^ b;
      default: return a - b;
    endcase
  endfunction

  assign alu_out      = toggle_en ? toggle_val : stub_f(alu_inp1, alu_inp2, alu_opc);
  assign alu_overflow = force_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Response scoreboard: one pop per handshake that will occur at the next edge.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("rsp", {12'h0, rsp_out, rsp_overflow, rsp_opc}, {12'h0, e});
      end
    end
  end

  task automatic offer(input logic [15:0] a, input logic [15:0] b, input logic [2:0] opc,
                       output bit acc);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_opc   = opc;
    @(negedge clk);
    acc = cmd_ready;
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back({stub_f(a, b, opc), force_ovf, opc});
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] opc);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      offer(a, b, opc, acc);
      n++;
    end
    cmd_valid = 1'b0;
    check("send_timeout", {31'h0, acc}, 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check("rsp_timeout", {31'h0, rsp_valid}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || rsp_valid || exp_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;

    // 1. reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("rst_alu_inp1", {16'h0, alu_inp1}, 32'd0);
    check("rst_alu_inp2", {16'h0, alu_inp2}, 32'd0);
    check("rst_alu_opc", {29'h0, alu_opc}, 32'd0);
    check("rst_ovf_count", {24'h0, ovf_count}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // 2. single command latency
    rsp_ready = 1'b1;
    send(16'h0004, 16'h0008, 3'b001);
    check("busy_after_accept", {31'h0, busy}, 32'd1);
    tick();
    check("lat_alu_inp1", {16'h0, alu_inp1}, 32'h0004);
    check("lat_alu_inp2", {16'h0, alu_inp2}, 32'h0008);
    check("lat_alu_opc", {29'h0, alu_opc}, 32'd1);
    check("lat_rsp_early", {31'h0, rsp_valid}, 32'd0);
    tick();
    check("lat_rsp_valid", {31'h0, rsp_valid}, 32'd1);
    check("lat_rsp_out", {16'h0, rsp_out}, 32'h000C);
    check("lat_rsp_opc", {29'h0, rsp_opc}, 32'd1);
    wait_idle();

    // 3. back-pressure fills the FIFO
    rsp_ready = 1'b0;
    begin
      int n_acc;
      n_acc = 0;
      for (int i = 0; i < 5; i++) begin
        offer(16'h0100 + 16'(i), 16'h0010, 3'b001, acc);
        if (acc) n_acc++;
      end
      for (int i = 0; i < 3; i++) begin
        offer(16'h0105, 16'h0010, 3'b001, acc);
        if (acc) n_acc++;
      end
      check("fill_accepted", 32'(n_acc), 32'd5);
      check("fill_cmd_ready", {31'h0, cmd_ready}, 32'd0);
      rsp_ready = 1'b1;
      offer(16'h0105, 16'h0010, 3'b001, acc);
      check("sixth_on_handshake", {31'h0, acc}, 32'd0);
      offer(16'h0105, 16'h0010, 3'b001, acc);
      check("sixth_after_handshake", {31'h0, acc}, 32'd1);
      cmd_valid = 1'b0;
    end
    wait_idle();

    // 4. response frozen under back-pressure while ALU output changes
    rsp_ready = 1'b0;
    send(16'h00F0, 16'h0F00, 3'b010);
    wait_rsp();
    toggle_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      toggle_val = (i % 2 == 0) ? 16'h2222 : 16'h1111;
      tick();
      check("hold_rsp_out", {16'h0, rsp_out}, 32'h0FF0);
      check("hold_alu_inp1", {16'h0, alu_inp1}, 32'h00F0);
      check("hold_rsp_valid", {31'h0, rsp_valid}, 32'd1);
    end
    toggle_en = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    // 5. overflow counting, clear priority, saturation
    force_ovf = 1'b1;
    for (int i = 0; i < 3; i++) send(16'h7000, 16'h7000 + 16'(i), 3'b001);
    wait_idle();
    check("ovf_three", {24'h0, ovf_count}, 32'd3);
    send(16'h7FFF, 16'h0001, 3'b001);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr_prio", {24'h0, ovf_count}, 32'd0);
    check("ovf_rsp_flag", {31'h0, rsp_overflow}, 32'd1);
    wait_idle();
    for (int i = 0; i < 255; i++) send(16'(i), 16'h8000, 3'b011);
    wait_idle();
    check("ovf_255", {24'h0, ovf_count}, 32'd255);
    for (int i = 0; i < 3; i++) send(16'h1234, 16'(i), 3'b011);
    wait_idle();
    check("ovf_saturate", {24'h0, ovf_count}, 32'd255);
    force_ovf = 1'b0;

    // 6. reset during WAIT with two commands queued
    rsp_ready = 1'b0;
    send(16'h0A00, 16'h0001, 3'b001);
    wait_rsp();
    send(16'h0B00, 16'h0002, 3'b001);
    send(16'h0C00, 16'h0003, 3'b001);
    send(16'h0D00, 16'h0004, 3'b001);
    rsp_ready = 1'b1;
    tick();
    check("pre_rst_alu_inp1", {16'h0, alu_inp1}, 32'h0B00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("wait_rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("wait_rst_busy", {31'h0, busy}, 32'd0);
    check("wait_rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    check("wait_rst_ovf", {24'h0, ovf_count}, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("dropped_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    check("dropped_busy", {31'h0, busy}, 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
